// File: rtl/poly_player_core_if.sv
// poly_player_core_if: voice/codec-side bundle of the multi-voice player core.
//   new_frame            raw codec frame strobe (level)
//   voice_samples        packed signed voice samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_valid          per-voice latch strobe
//   voice_enable         per-voice mix mask
//   volume               arithmetic right shift applied to the mix sum
//   generate_next_sample one-cycle pulse per frame
//   new_sample_generated copy of generate_next_sample
//   sample_out           frame-synchronised mixed sample
//   clip                 sticky saturation flag
// The master modport is the note-player/codec side, the slave modport is the core.
interface poly_player_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_W      = 3
) ();
  logic                           new_frame;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples;
  logic [NUM_VOICES-1:0]          voice_valid;
  logic [NUM_VOICES-1:0]          voice_enable;
  logic [VOL_W-1:0]               volume;
  logic                           generate_next_sample;
  logic                           new_sample_generated;
  logic [SAMPLE_W-1:0]            sample_out;
  logic                           clip;

  modport master (
    output new_frame, voice_samples, voice_valid, voice_enable, volume,
    input  generate_next_sample, new_sample_generated, sample_out, clip
  );

  modport slave (
    input  new_frame, voice_samples, voice_valid, voice_enable, volume,
    output generate_next_sample, new_sample_generated, sample_out, clip
  );
endinterface

// File: rtl/poly_player_core.sv
// poly_player_core: control-and-output core of the multi-voice music player.
//   clk, reset      single clock, synchronous active-low reset
//   play_button     one-cycle pulse, toggles play/pause
//   next_button     one-cycle pulse, advances to the next song
//   song_done       one-cycle pulse from song_reader at end of song
//   play            high while playing
//   reset_play      one-cycle pulse resetting song_reader
//   song            current song index
//   beat            one-cycle pulse every BEAT_COUNT played frames
//   play_led        ~play (active-low LED)
//   song_led        ~song (active-low LEDs)
//   bus             voice latch inputs, frame strobe, mixed sample output
module poly_player_core #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int BEAT_COUNT = 1000,
  parameter int VOL_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song,
  output logic              beat,
  output logic              play_led,
  output logic [SONG_W-1:0] song_led,
  poly_player_if.slave      bus
);

  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int BEAT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

  typedef enum logic [1:0] {
    RESET_PLAYER = 2'd0,
    PAUSED       = 2'd1,
    PLAYING      = 2'd2,
    NEXT_SONG    = 2'd3
  } state_e;

  // Sign-extend one voice sample to the accumulator width.
  function automatic logic signed [SUM_W-1:0] sext(input logic signed [SAMPLE_W-1:0] v);
    return {{(SUM_W-SAMPLE_W){v[SAMPLE_W-1]}}, v};
  endfunction

  // True when the value does not fit in SAMPLE_W signed bits: the bits from
  // the output sign bit upwards are not all equal.
  function automatic logic overflows(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-SAMPLE_W:0] top;
    top = v[SUM_W-1:SAMPLE_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (!overflows(v))
      return $signed(v[SAMPLE_W-1:0]);
    else if (v[SUM_W-1])
      return $signed({1'b1, {(SAMPLE_W-1){1'b0}}});
    else
      return $signed({1'b0, {(SAMPLE_W-1){1'b1}}});
  endfunction

  state_e                      state_q, state_d;
  logic                        resume_q, resume_d;
  logic [SONG_W-1:0]           song_q, song_d;
  logic                        play_q, play_d;
  logic                        reset_play_q, reset_play_d;
  logic                        nf_q, nf_d;
  logic                        gns_q, gns_d;
  logic                        beat_q, beat_d;
  logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                        clip_q, clip_d;
  logic signed [SAMPLE_W-1:0]  held_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0]  held_d [NUM_VOICES];

  logic                        frame_edge;
  logic signed [SUM_W-1:0]     mix_sum;
  logic signed [SUM_W-1:0]     mix_shift;

  // Control FSM. play/reset_play are decoded from the current state and
  // registered, so they trail the state register by one cycle; this is what
  // makes the RESET_PLAYER cycle that follows power-on reset visible as a
  // reset_play pulse while keeping every pulse output low during reset.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    song_d   = song_q;
    case (state_q)
      RESET_PLAYER: state_d = resume_q ? PLAYING : PAUSED;
      PAUSED: begin
        if (next_button) begin
          state_d  = NEXT_SONG;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (next_button || song_done) begin
          state_d  = NEXT_SONG;
          resume_d = 1'b1;
        end else if (play_button) begin
          state_d = PAUSED;
        end
      end
      NEXT_SONG: begin
        song_d  = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);
        state_d = RESET_PLAYER;
      end
      default: state_d = RESET_PLAYER;
    endcase
    play_d       = (state_q == PLAYING);
    reset_play_d = (state_q == RESET_PLAYER);
  end

  // Voice latch: the mix reads the registered copies, so a strobe landing in
  // the frame-edge cycle only shows up in the following frame.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      held_d[i] = held_q[i];
      if (bus.voice_valid[i])
        held_d[i] = $signed(bus.voice_samples[i*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // Mix: widened signed sum of enabled voices, volume shift, saturation.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (bus.voice_enable[i])
        mix_sum = mix_sum + sext(held_q[i]);
    end
    mix_shift = mix_sum >>> bus.volume;
  end

  // Frame output and beat generation, registered at the end of the edge cycle.
  always_comb begin
    nf_d       = bus.new_frame;
    frame_edge = bus.new_frame & ~nf_q;
    gns_d      = frame_edge;
    sample_d   = sample_q;
    clip_d     = clip_q;
    beat_d     = 1'b0;
    beat_cnt_d = beat_cnt_q;
    if (frame_edge) begin
      sample_d = play_q ? sat(mix_shift) : '0;
      if (play_q && overflows(mix_shift))
        clip_d = 1'b1;
    end
    if (reset_play_q) begin
      beat_cnt_d = '0;
    end else if (frame_edge && play_q) begin
      if (beat_cnt_q == BEAT_W'(BEAT_COUNT - 1)) begin
        beat_cnt_d = '0;
        beat_d     = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RESET_PLAYER;
      resume_q     <= 1'b0;
      song_q       <= '0;
      play_q       <= 1'b0;
      reset_play_q <= 1'b0;
      nf_q         <= 1'b0;
      gns_q        <= 1'b0;
      beat_q       <= 1'b0;
      beat_cnt_q   <= '0;
      sample_q     <= '0;
      clip_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++)
        held_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      song_q       <= song_d;
      play_q       <= play_d;
      reset_play_q <= reset_play_d;
      nf_q         <= nf_d;
      gns_q        <= gns_d;
      beat_q       <= beat_d;
      beat_cnt_q   <= beat_cnt_d;
      sample_q     <= sample_d;
      clip_q       <= clip_d;
      for (int i = 0; i < NUM_VOICES; i++)
        held_q[i] <= held_d[i];
    end
  end

  assign play                     = play_q;
  assign reset_play               = reset_play_q;
  assign song                     = song_q;
  assign beat                     = beat_q;
  assign play_led                 = ~play_q;
  assign song_led                 = ~song_q;
  assign bus.generate_next_sample = gns_q;
  assign bus.new_sample_generated = gns_q;
  assign bus.sample_out           = sample_q;
  assign bus.clip                 = clip_q;

endmodule

// File: tb/tb_poly_player_core.sv
// tb_poly_player_core: directed bench for poly_player_core (NUM_SONGS=3,
// BEAT_COUNT=4). Frame results are queued when a frame is issued and checked
// by a separate monitor whenever generate_next_sample is seen.
module tb_poly_player_core;

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       play;
  logic       reset_play;
  logic [1:0] song;
  logic       beat;
  logic       play_led;
  logic [1:0] song_led;

  poly_player_if #(.NUM_VOICES(4), .SAMPLE_W(16), .VOL_W(3)) bus ();

  poly_player_core #(
    .NUM_VOICES(4), .SAMPLE_W(16), .NUM_SONGS(3), .SONG_W(2),
    .BEAT_COUNT(4), .VOL_W(3)
  ) dut (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .song_done(song_done), .play(play),
    .reset_play(reset_play), .song(song), .beat(beat),
    .play_led(play_led), .song_led(song_led), .bus(bus)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        b;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rp_count = 0;
  int   gns_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every frame pulse pops one expected result.
  always @(negedge clk) begin
    if (reset_play) rp_count++;
    if (bus.generate_next_sample) begin
      exp_t e;
      gns_count++;
      check("nsg_copy", {31'd0, bus.new_sample_generated}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got sample %0h, expected no pulse", bus.sample_out);
      end else begin
        e = exp_q.pop_front();
        check("frame_sample", {16'd0, bus.sample_out}, {16'd0, e.s});
        check("frame_beat", {31'd0, beat}, {31'd0, e.b});
        check("frame_clip", {31'd0, bus.clip}, {31'd0, e.c});
      end
    end else if (beat) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_without_frame: got beat 1, expected 0");
    end
  end

  task automatic frame(input logic [15:0] s, input logic b, input logic c);
    exp_q.push_back('{s: s, b: b, c: c});
    bus.new_frame = 1'b1;
    tick(1);
    bus.new_frame = 1'b0;
    tick(3);
  endtask

  task automatic pulse_play();
    play_button = 1'b1;
    tick(1);
    play_button = 1'b0;
  endtask

  task automatic latch_all(input logic [15:0] v);
    bus.voice_samples = {v, v, v, v};
    bus.voice_valid   = 4'hF;
    tick(1);
    bus.voice_valid   = 4'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_play"}, {31'd0, play}, 32'd0);
    check({tag, "_reset_play"}, {31'd0, reset_play}, 32'd0);
    check({tag, "_song"}, {30'd0, song}, 32'd0);
    check({tag, "_beat"}, {31'd0, beat}, 32'd0);
    check({tag, "_gns"}, {31'd0, bus.generate_next_sample}, 32'd0);
    check({tag, "_sample"}, {16'd0, bus.sample_out}, 32'd0);
    check({tag, "_clip"}, {31'd0, bus.clip}, 32'd0);
    check({tag, "_play_led"}, {31'd0, play_led}, 32'd1);
    check({tag, "_song_led"}, {30'd0, song_led}, 32'd3);
  endtask

  initial begin
    int rp0;
    int g0;
    reset             = 1'b0;
    play_button       = 1'b0;
    next_button       = 1'b0;
    song_done         = 1'b0;
    bus.new_frame     = 1'b0;
    bus.voice_samples = '0;
    bus.voice_valid   = '0;
    bus.voice_enable  = 4'hF;
    bus.volume        = 3'd0;
    tick(3);
    check_reset_outputs("rst");

    // Release reset, then press play.
    rp0   = rp_count;
    reset = 1'b1;
    tick(1);
    check("post_rst_reset_play", {31'd0, reset_play}, 32'd1);
    play_button = 1'b1;
    tick(1);
    play_button = 1'b0;
    check("post_rst_play_early", {31'd0, play}, 32'd0);
    tick(1);
    check("play_on", {31'd0, play}, 32'd1);
    check("play_led_on", {31'd0, play_led}, 32'd0);
    check("song0", {30'd0, song}, 32'd0);
    check("song_led0", {30'd0, song_led}, 32'd3);
    check("rp_after_release", rp_count - rp0, 32'd1);

    // Pause, then three next_button presses while paused.
    pulse_play();
    tick(2);
    check("paused", {31'd0, play}, 32'd0);
    rp0 = rp_count;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] seq [3];
      seq = '{2'd1, 2'd2, 2'd0};
      next_button = 1'b1;
      tick(1);
      next_button = 1'b0;
      tick(4);
      check("next_song", {30'd0, song}, {30'd0, seq[k]});
      check("next_play", {31'd0, play}, 32'd0);
    end
    check("next_rp_count", rp_count - rp0, 32'd3);

    // Auto-advance on song_done while playing.
    pulse_play();
    tick(2);
    check("play_again", {31'd0, play}, 32'd1);
    rp0       = rp_count;
    song_done = 1'b1;
    tick(1);
    song_done = 1'b0;
    tick(2);
    check("auto_play_drop", {31'd0, play}, 32'd0);
    tick(2);
    check("auto_song", {30'd0, song}, 32'd1);
    check("auto_play", {31'd0, play}, 32'd1);
    check("auto_rp_count", rp_count - rp0, 32'd1);

    // Mix arithmetic (beat counter restarted by reset_play).
    latch_all(16'h4000);
    frame(16'h7FFF, 1'b0, 1'b1);
    bus.volume = 3'd2;
    frame(16'h4000, 1'b0, 1'b1);
    bus.volume = 3'd0;
    latch_all(16'hD000);
    frame(16'h8000, 1'b0, 1'b1);
    // Latch coincident with the edge: this frame still mixes the old values.
    exp_q.push_back('{s: 16'h8000, b: 1'b1, c: 1'b1});
    bus.voice_samples = {4{16'h0100}};
    bus.voice_valid   = 4'hF;
    bus.new_frame     = 1'b1;
    tick(1);
    bus.voice_valid   = 4'h0;
    bus.new_frame     = 1'b0;
    tick(3);
    frame(16'h0400, 1'b0, 1'b1);
    bus.voice_enable = 4'b0001;
    bus.volume       = 3'd1;
    frame(16'h0080, 1'b0, 1'b1);
    bus.voice_enable = 4'b0000;
    frame(16'h0000, 1'b0, 1'b1);
    bus.voice_enable = 4'hF;
    bus.volume       = 3'd0;

    // Beat: restart count via next song, 5 frames, pause, resume, 3 frames.
    next_button = 1'b1;
    tick(1);
    next_button = 1'b0;
    tick(6);
    check("beat_song", {30'd0, song}, 32'd2);
    check("beat_play", {31'd0, play}, 32'd1);
    g0 = gns_count;
    frame(16'h0400, 1'b0, 1'b1);
    frame(16'h0400, 1'b0, 1'b1);
    frame(16'h0400, 1'b0, 1'b1);
    frame(16'h0400, 1'b1, 1'b1);
    frame(16'h0400, 1'b0, 1'b1);
    pulse_play();
    tick(3);
    frame(16'h0000, 1'b0, 1'b1);
    frame(16'h0000, 1'b0, 1'b1);
    pulse_play();
    tick(3);
    frame(16'h0400, 1'b0, 1'b1);
    frame(16'h0400, 1'b0, 1'b1);
    frame(16'h0400, 1'b1, 1'b1);
    check("beat_frame_count", gns_count - g0, 32'd10);

    // new_frame held high for 10 cycles gives one frame.
    g0 = gns_count;
    exp_q.push_back('{s: 16'h0400, b: 1'b0, c: 1'b1});
    bus.new_frame = 1'b1;
    tick(10);
    bus.new_frame = 1'b0;
    tick(3);
    check("stuck_frame_count", gns_count - g0, 32'd1);

    // Reset asserted in the edge cycle discards the frame.
    g0            = gns_count;
    bus.new_frame = 1'b1;
    reset         = 1'b0;
    tick(1);
    check_reset_outputs("mid_rst");
    bus.new_frame = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    check("mid_rst_frame_count", gns_count - g0, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
